// File: rtl/demux_pkg.sv
//------------------------------------------------------------------------------
// demux_pkg : shared mode encoding, default sizes and pointer wrap helper
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package demux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LANES  = 2;

  // Wraps at the lane count, not at a power of two.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned lanes);
    return (ptr + 32'd1 >= lanes) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_lane_reg.sv
//------------------------------------------------------------------------------
// demux_lane_reg : one-entry valid/ready output register for a single lane
// Macro DEMUX_HOLD_EN: keep last word on drain instead of clearing it.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module demux_lane_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              w_drain;

  assign w_drain = r_valid && i_ready;

  // Load wins over drain so a drain+reload cycle keeps valid high with no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (w_drain) begin
      r_valid <= 1'b0;
`ifdef DEMUX_HOLD_EN
      r_data  <= r_data;
`else
      r_data  <= '0;
`endif
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/demux_rr_nlane.sv
//------------------------------------------------------------------------------
// demux_rr_nlane : 1-to-LANES valid/ready demux, round-robin or selector routed
// Macro DEMUX_HOLD_EN (in demux_lane_reg): drained lanes hold their last word.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module demux_rr_nlane
  import demux_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int LANES  = DEF_LANES,
  localparam int SEL_W  = $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode_rr,
  input  logic [SEL_W-1:0]        selector,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES*DATA_W-1:0] out_data,
  input  logic [LANES-1:0]        out_ready,
  output logic [SEL_W-1:0]        lane_ptr,
  output logic                    err_sel
);

  logic [SEL_W-1:0] r_ptr;
  logic             r_err;
  logic [SEL_W-1:0] w_tgt;
  logic             w_in_range;
  logic             w_tgt_free;
  logic             w_accept;
  logic [LANES-1:0] w_load;

  assign w_tgt = (mode_e'(mode_rr) == MODE_RR) ? r_ptr : selector;

  // An out-of-range target is always "free": the word is swallowed and flagged.
  always_comb begin
    w_in_range = 1'b0;
    w_tgt_free = 1'b1;
    w_load     = '0;
    for (int k = 0; k < LANES; k++) begin
      if (w_tgt == SEL_W'(k)) begin
        w_in_range = 1'b1;
        w_tgt_free = !out_valid[k] || out_ready[k];
      end
    end
    for (int k = 0; k < LANES; k++) begin
      w_load[k] = w_accept && (w_tgt == SEL_W'(k));
    end
  end

  assign in_ready = !reset && w_tgt_free;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept && !w_in_range;
      if (w_accept && (mode_e'(mode_rr) == MODE_RR)) begin
        r_ptr <= SEL_W'(next_ptr(32'(r_ptr), LANES));
      end
    end
  end

  assign lane_ptr = r_ptr;
  assign err_sel  = r_err;

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      demux_lane_reg #(
        .DATA_W (DATA_W)
      ) u_lane (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load[k]),
        .i_data  (in_data),
        .i_ready (out_ready[k]),
        .o_valid (out_valid[k]),
        .o_data  (out_data[k*DATA_W +: DATA_W])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_demux_rr_nlane.sv
//------------------------------------------------------------------------------
// tb_demux_rr_nlane : two instances (LANES=2 and LANES=3) driven by shared stimulus
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_demux_rr_nlane;

  logic       clk = 1'b0;
  logic       tb_rst;
  logic       tb_mode;
  logic [1:0] tb_sel;
  logic       tb_in_valid;
  logic [7:0] tb_in_data;
  logic [2:0] tb_ordy;

  logic        o2_rdy, o2_err;
  logic [1:0]  o2_valid;
  logic [15:0] o2_data;
  logic [0:0]  o2_ptr;
  logic        o3_rdy, o3_err;
  logic [2:0]  o3_valid;
  logic [23:0] o3_data;
  logic [1:0]  o3_ptr;

  int checks = 0;
  int errors = 0;

  // Reference state: each lane is a single slot, pointer is a plain integer.
  logic       m_v[2][3];
  logic [7:0] m_d[2][3];
  int         m_ptr[2];
  logic       m_err[2];

  always #5 clk = ~clk;

  demux_rr_nlane #(.DATA_W(8), .LANES(2)) u_dut2 (
    .clk(clk), .reset(tb_rst), .mode_rr(tb_mode), .selector(tb_sel[0:0]),
    .in_valid(tb_in_valid), .in_data(tb_in_data), .in_ready(o2_rdy),
    .out_valid(o2_valid), .out_data(o2_data), .out_ready(tb_ordy[1:0]),
    .lane_ptr(o2_ptr), .err_sel(o2_err)
  );

  demux_rr_nlane #(.DATA_W(8), .LANES(3)) u_dut3 (
    .clk(clk), .reset(tb_rst), .mode_rr(tb_mode), .selector(tb_sel),
    .in_valid(tb_in_valid), .in_data(tb_in_data), .in_ready(o3_rdy),
    .out_valid(o3_valid), .out_data(o3_data), .out_ready(tb_ordy),
    .lane_ptr(o3_ptr), .err_sel(o3_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic       n_v[2][3];
    logic [7:0] n_d[2][3];
    int         n_ptr[2];
    logic       n_err[2];
    int         tgt, L;
    bit         inr, rdy, acc;
    logic [2:0]  ev;
    logic [23:0] ed;
    #1;
    for (int d = 0; d < 2; d++) begin
      L   = d + 2;
      tgt = tb_mode ? m_ptr[d] : ((d == 0) ? int'(tb_sel[0]) : int'(tb_sel));
      inr = (tgt < L);
      rdy = !tb_rst;
      if (rdy && inr) rdy = !m_v[d][tgt] || tb_ordy[tgt];
      acc = tb_in_valid && rdy;
      chk(d == 0 ? "in_ready_L2" : "in_ready_L3", d == 0 ? 32'(o2_rdy) : 32'(o3_rdy), 32'(rdy));
      for (int k = 0; k < 3; k++) begin
        n_v[d][k] = m_v[d][k];
        n_d[d][k] = m_d[d][k];
        if (k < L) begin
          if (acc && inr && tgt == k) begin
            n_v[d][k] = 1'b1;
            n_d[d][k] = tb_in_data;
          end else if (m_v[d][k] && tb_ordy[k]) begin
            n_v[d][k] = 1'b0;
`ifndef DEMUX_HOLD_EN
            n_d[d][k] = 8'h00;
`endif
          end
        end
        if (tb_rst) begin
          n_v[d][k] = 1'b0;
          n_d[d][k] = 8'h00;
        end
      end
      n_err[d] = !tb_rst && acc && !inr;
      n_ptr[d] = tb_rst ? 0 : ((acc && tb_mode) ? (m_ptr[d] + 1) % L : m_ptr[d]);
    end
    @(posedge clk);
    #1;
    m_v = n_v; m_d = n_d; m_ptr = n_ptr; m_err = n_err;
    for (int d = 0; d < 2; d++) begin
      ev = '0; ed = '0;
      for (int k = 0; k < d + 2; k++) begin
        ev[k]        = m_v[d][k];
        ed[k*8 +: 8] = m_d[d][k];
      end
      chk(d == 0 ? "out_valid_L2" : "out_valid_L3", d == 0 ? 32'(o2_valid) : 32'(o3_valid), 32'(ev));
      chk(d == 0 ? "out_data_L2"  : "out_data_L3",  d == 0 ? 32'(o2_data)  : 32'(o3_data),  32'(ed));
      chk(d == 0 ? "lane_ptr_L2"  : "lane_ptr_L3",  d == 0 ? 32'(o2_ptr)   : 32'(o3_ptr),   32'(m_ptr[d]));
      chk(d == 0 ? "err_sel_L2"   : "err_sel_L3",   d == 0 ? 32'(o2_err)   : 32'(o3_err),   32'(m_err[d]));
    end
  endtask

  task automatic send(input logic [7:0] data);
    tb_in_valid = 1'b1;
    tb_in_data  = data;
    step();
  endtask

  task automatic idle(input int n);
    tb_in_valid = 1'b0;
    tb_in_data  = 8'($urandom);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_err[d] = 1'b0;
      for (int k = 0; k < 3; k++) begin m_v[d][k] = 1'b0; m_d[d][k] = 8'h00; end
    end
    tb_rst = 1'b1; tb_mode = 1'b1; tb_sel = 2'd0; tb_ordy = 3'b000;
    tb_in_valid = 1'b1; tb_in_data = 8'hA5;

    // Reset held two cycles with in_valid asserted
    step(); step();
    tb_rst = 1'b0;

    // Round-robin, all sinks ready
    tb_ordy = 3'b111;
    send(8'h10); send(8'h12); send(8'h0A); send(8'h14);
    idle(2);

    // Backpressure, then release lane 0
    tb_ordy = 3'b000;
    send(8'h01); send(8'h02); send(8'h03); send(8'h03);
    tb_ordy = 3'b001;
    send(8'h03);
    idle(1);
    tb_ordy = 3'b111;
    idle(2);

    // Selector mode, including out-of-range selector on the 3-lane instance
    tb_mode = 1'b0;
    tb_sel = 2'd2; send(8'h55);
    tb_sel = 2'd3; send(8'h66);
    idle(2);

    // Reset mid-stream with full lanes
    tb_mode = 1'b1; tb_ordy = 3'b000;
    send(8'hAA); send(8'hBB);
    tb_rst = 1'b1; idle(1);
    tb_rst = 1'b0; tb_ordy = 3'b111;
    send(8'hCC);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      tb_rst      = ($urandom_range(0, 40) == 0);
      tb_mode     = 1'($urandom);
      tb_sel      = 2'($urandom);
      tb_ordy     = 3'($urandom);
      tb_in_valid = 1'($urandom);
      tb_in_data  = 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
